// File: rtl/lcd_result_writer.sv
// Formats a CPU result (opcode, destination register, signed value) as two text lines
// and writes them to an HD44780-compatible character LCD over the 8-bit bus.
`timescale 1ns/1ps

module lcd_result_writer #(
    parameter int POWERUP_CYC = 750000,
    parameter int EN_CYC      = 12,
    parameter int CMD_CYC     = 2000,
    parameter int CLR_CYC     = 82000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [3:0]  addr,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on
);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_CONVERT,
        ST_WRITE
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EN,
        PH_WAIT
    } phase_t;

    localparam logic [31:0] PWR_LAST = 32'(POWERUP_CYC - 1);
    localparam logic [31:0] EN_LAST  = 32'(EN_CYC - 1);
    localparam logic [31:0] CMD_LAST = 32'(CMD_CYC - 1);
    localparam logic [31:0] CLR_LAST = 32'(CLR_CYC - 1);

    localparam logic [5:0] INIT_LAST_BYTE  = 6'd3;
    localparam logic [5:0] WRITE_LAST_BYTE = 6'd33;

    state_t      state_reg, state_next;
    phase_t      phase_reg, phase_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [5:0]  byte_idx_reg, byte_idx_next;
    logic [1:0]  div_idx_reg, div_idx_next;
    logic [16:0] mag_reg, mag_next;
    logic [19:0] digits_reg, digits_next;
    logic [2:0]  opcode_reg, opcode_next;
    logic [3:0]  addr_reg, addr_next;
    logic        sign_reg, sign_next;
    logic        done_reg, done_next;

    logic [7:0]  cur_data;
    logic        cur_rs;
    logic [3:0]  char_pos;
    logic [31:0] wait_last;
    logic [16:0] div_val;
    logic [31:0] mnem;
    logic [7:0]  hex_chr;
    logic [7:0]  sign_chr;
    logic [7:0]  line1_chr [16];
    logic [7:0]  line2_chr [16];

    // ------------------------------------------------------------------
    // Text formatting of the captured operands
    // ------------------------------------------------------------------
    always_comb begin
        mnem = "LOAD";
        case (opcode_reg)
            3'b000:  mnem = "LOAD";
            3'b001:  mnem = "ADD ";
            3'b010:  mnem = "ADDI";
            3'b011:  mnem = "SUB ";
            3'b100:  mnem = "SUBI";
            3'b101:  mnem = "MUL ";
            3'b110:  mnem = "CLR ";
            default: mnem = "DISP";
        endcase
    end

    assign hex_chr  = (addr_reg < 4'd10) ? (8'h30 + {4'h0, addr_reg})
                                         : (8'h37 + {4'h0, addr_reg});
    assign sign_chr = sign_reg ? 8'h2D : 8'h2B;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_line
            if (gi < 4) begin : g_mnem
                assign line1_chr[gi] = mnem[31-8*gi -: 8];
            end else if (gi == 5) begin : g_r
                assign line1_chr[gi] = 8'h52;
            end else if (gi == 6) begin : g_hex
                assign line1_chr[gi] = hex_chr;
            end else begin : g_sp1
                assign line1_chr[gi] = 8'h20;
            end

            if (gi == 0) begin : g_eq
                assign line2_chr[gi] = 8'h3D;
            end else if (gi == 1) begin : g_sign
                assign line2_chr[gi] = sign_chr;
            end else if (gi < 7) begin : g_digit
                assign line2_chr[gi] = 8'h30 + {4'h0, digits_reg[4*(gi-2) +: 4]};
            end else begin : g_sp2
                assign line2_chr[gi] = 8'h20;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Byte currently presented on the bus
    // ------------------------------------------------------------------
    always_comb begin
        cur_data = 8'h00;
        cur_rs   = 1'b0;
        char_pos = 4'(byte_idx_reg - 6'd1);
        if (state_reg == ST_INIT) begin
            case (byte_idx_reg[1:0])
                2'd0:    cur_data = 8'h38;
                2'd1:    cur_data = 8'h0C;
                2'd2:    cur_data = 8'h01;
                default: cur_data = 8'h06;
            endcase
        end else if (state_reg == ST_WRITE) begin
            if (byte_idx_reg == 6'd0) begin
                cur_data = 8'h80;
            end else if (byte_idx_reg <= 6'd16) begin
                cur_rs   = 1'b1;
                cur_data = line1_chr[char_pos];
            end else if (byte_idx_reg == 6'd17) begin
                cur_data = 8'hC0;
            end else begin
                char_pos = 4'(byte_idx_reg - 6'd18);
                cur_rs   = 1'b1;
                cur_data = line2_chr[char_pos];
            end
        end
    end

    // Clear-display needs the long settle time; everything else the short one.
    assign wait_last = (!cur_rs && cur_data == 8'h01) ? CLR_LAST : CMD_LAST;

    always_comb begin
        case (div_idx_reg)
            2'd0:    div_val = 17'd10000;
            2'd1:    div_val = 17'd1000;
            2'd2:    div_val = 17'd100;
            default: div_val = 17'd10;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_PWRUP;
            phase_reg    <= PH_SETUP;
            cnt_reg      <= 32'd0;
            byte_idx_reg <= 6'd0;
            div_idx_reg  <= 2'd0;
            mag_reg      <= 17'd0;
            digits_reg   <= 20'd0;
            opcode_reg   <= 3'd0;
            addr_reg     <= 4'd0;
            sign_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            cnt_reg      <= cnt_next;
            byte_idx_reg <= byte_idx_next;
            div_idx_reg  <= div_idx_next;
            mag_reg      <= mag_next;
            digits_reg   <= digits_next;
            opcode_reg   <= opcode_next;
            addr_reg     <= addr_next;
            sign_reg     <= sign_next;
            done_reg     <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        cnt_next      = cnt_reg;
        byte_idx_next = byte_idx_reg;
        div_idx_next  = div_idx_reg;
        mag_next      = mag_reg;
        digits_next   = digits_reg;
        opcode_next   = opcode_reg;
        addr_next     = addr_reg;
        sign_next     = sign_reg;
        done_next     = 1'b0;

        case (state_reg)
            ST_PWRUP: begin
                if (cnt_reg == PWR_LAST) begin
                    state_next    = ST_INIT;
                    phase_next    = PH_SETUP;
                    cnt_next      = 32'd0;
                    byte_idx_next = 6'd0;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end

            ST_INIT, ST_WRITE: begin
                case (phase_reg)
                    PH_SETUP: begin
                        phase_next = PH_EN;
                        cnt_next   = 32'd0;
                    end
                    PH_EN: begin
                        if (cnt_reg == EN_LAST) begin
                            phase_next = PH_WAIT;
                            cnt_next   = 32'd0;
                        end else begin
                            cnt_next = cnt_reg + 32'd1;
                        end
                    end
                    default: begin
                        if (cnt_reg == wait_last) begin
                            cnt_next   = 32'd0;
                            phase_next = PH_SETUP;
                            if (state_reg == ST_INIT && byte_idx_reg == INIT_LAST_BYTE) begin
                                state_next = ST_IDLE;
                            end else if (state_reg == ST_WRITE && byte_idx_reg == WRITE_LAST_BYTE) begin
                                state_next = ST_IDLE;
                                done_next  = 1'b1;
                            end else begin
                                byte_idx_next = byte_idx_reg + 6'd1;
                            end
                        end else begin
                            cnt_next = cnt_reg + 32'd1;
                        end
                    end
                endcase
            end

            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_CONVERT;
                    opcode_next  = opcode;
                    addr_next    = addr;
                    sign_next    = value[15];
                    mag_next     = value[15] ? (17'd0 - {1'b1, value}) : {1'b0, value};
                    digits_next  = 20'd0;
                    div_idx_next = 2'd0;
                end
            end

            ST_CONVERT: begin
                // One subtraction or one digit advance per cycle.
                if (mag_reg >= div_val) begin
                    mag_next = mag_reg - div_val;
                    digits_next[4*div_idx_reg +: 4] = digits_reg[4*div_idx_reg +: 4] + 4'd1;
                end else if (div_idx_reg == 2'd3) begin
                    digits_next[19:16] = mag_reg[3:0];
                    state_next         = ST_WRITE;
                    phase_next         = PH_SETUP;
                    cnt_next           = 32'd0;
                    byte_idx_next      = 6'd0;
                end else begin
                    div_idx_next = div_idx_reg + 2'd1;
                end
            end

            default: begin
                state_next = ST_PWRUP;
                cnt_next   = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign lcd_data = cur_data;
    assign lcd_rs   = cur_rs;
    assign lcd_en   = (state_reg == ST_INIT || state_reg == ST_WRITE) && (phase_reg == PH_EN);
    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;

endmodule

// File: tb/tb_lcd_result_writer.sv
// Directed bench for lcd_result_writer: logs {rs,data} on every lcd_en fall and
// compares the decoded command/text stream against hand-computed lines.
`timescale 1ns/1ps

module tb_lcd_result_writer;

    localparam int P_PWR = 20;
    localparam int P_EN  = 2;
    localparam int P_CMD = 4;
    localparam int P_CLR = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  opcode = 3'd0;
    logic [3:0]  addr = 4'd0;
    logic [15:0] value = 16'd0;
    logic        busy, done, lcd_rs, lcd_rw, lcd_en, lcd_on;
    logic [7:0]  lcd_data;

    lcd_result_writer #(
        .POWERUP_CYC(P_PWR),
        .EN_CYC     (P_EN),
        .CMD_CYC    (P_CMD),
        .CLR_CYC    (P_CLR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .opcode  (opcode),
        .addr    (addr),
        .value   (value),
        .busy    (busy),
        .done    (done),
        .lcd_data(lcd_data),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_en  (lcd_en),
        .lcd_on  (lcd_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  ad;
        logic [15:0] val;
        string       l1;
        string       l2;
    } vec_t;

    vec_t vecs [7];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] log_q [$];
    int         gaps [$];
    int         done_cnt = 0;
    bit         seen_fall = 0;
    logic       en_prev = 1'b0;
    int         low_run = 0;

    always @(negedge lcd_en) log_q.push_back({lcd_rs, lcd_data});

    // Done pulses and lcd_en-low run lengths between byte strobes.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (lcd_en === 1'b1) begin
            if (!en_prev && seen_fall) gaps.push_back(low_run);
        end else begin
            if (en_prev) begin
                seen_fall = 1;
                low_run   = 1;
            end else begin
                low_run++;
            end
        end
        en_prev = (lcd_en === 1'b1);
    end

    function automatic string pad16(string s);
        string r = s;
        while (r.len() < 16) r = {r, " "};
        return r;
    endfunction

    task automatic set_vec(int i, logic [2:0] op, logic [3:0] ad, logic [15:0] val,
                           string l1, string l2);
        vecs[i].op  = op;
        vecs[i].ad  = ad;
        vecs[i].val = val;
        vecs[i].l1  = pad16(l1);
        vecs[i].l2  = pad16(l2);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_str(string name, string act, string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic check_init(string tag);
        logic [8:0] exp_q [4];
        exp_q[0] = 9'h038;
        exp_q[1] = 9'h00C;
        exp_q[2] = 9'h001;
        exp_q[3] = 9'h006;
        check({tag, "_count"}, log_q.size(), 32'd4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("%s_byte%0d", tag, i), {23'd0, log_q[i]}, {23'd0, exp_q[i]});
        end
    endtask

    // Decodes one 34-byte refresh starting at log entry base.
    task automatic check_log(string tag, int base, string l1, string l2);
        string s1 = "";
        string s2 = "";
        int    rs_bad = 0;
        check({tag, "_bytes"}, 32'(log_q.size() >= base + 34), 32'd1);
        if (log_q.size() >= base + 34) begin
            for (int i = 0; i < 16; i++) begin
                s1 = $sformatf("%s%c", s1, log_q[base + 1 + i][7:0]);
                s2 = $sformatf("%s%c", s2, log_q[base + 18 + i][7:0]);
                if (log_q[base + 1 + i][8] !== 1'b1) rs_bad++;
                if (log_q[base + 18 + i][8] !== 1'b1) rs_bad++;
            end
            check({tag, "_cmd80"}, {23'd0, log_q[base]}, 32'h080);
            check_str({tag, "_line1"}, s1, l1);
            check({tag, "_cmdC0"}, {23'd0, log_q[base + 17]}, 32'h0C0);
            check_str({tag, "_line2"}, s2, l2);
            check({tag, "_rs_chars"}, rs_bad, 32'd0);
        end
    endtask

    task automatic pulse_start(logic [2:0] op, logic [3:0] ad, logic [15:0] val);
        opcode = op;
        addr   = ad;
        value  = val;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        set_vec(0, 3'b010, 4'h5, 16'h0007, "ADDI R5", "=+00007");
        set_vec(1, 3'b000, 4'h0, 16'h8000, "LOAD R0", "=-32768");
        set_vec(2, 3'b011, 4'hA, 16'hFFFF, "SUB  RA", "=-00001");
        set_vec(3, 3'b101, 4'h3, 16'h7FFF, "MUL  R3", "=+32767");
        set_vec(4, 3'b110, 4'hC, 16'h0000, "CLR  RC", "=+00000");
        set_vec(5, 3'b001, 4'h9, 16'h04D2, "ADD  R9", "=+01234");
        set_vec(6, 3'b100, 4'hE, 16'hFB2E, "SUBI RE", "=-01234");

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_en", {31'd0, lcd_en}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", {24'd0, lcd_data}, 32'd0);
        check("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check("rw_on", {30'd0, lcd_rw, lcd_on}, 32'd1);
        log_q.delete();
        gaps.delete();
        seen_fall = 0;
        rst = 1'b0;

        // Power-up and init sequence; en-low run = settle wait plus the next setup cycle
        wait_idle("init_idle");
        check_init("init");
        check("init_gap_count", gaps.size(), 32'd3);
        if (gaps.size() == 3) begin
            check("gap_after_38", gaps[0], P_CMD + 1);
            check("gap_after_0C", gaps[1], P_CMD + 1);
            check("gap_after_01", gaps[2], P_CLR + 1);
        end

        // Table-driven back-to-back refreshes
        for (int v = 0; v < 7; v++) begin
            wait_idle($sformatf("vec%0d_idle", v));
            log_q.delete();
            done_cnt = 0;
            pulse_start(vecs[v].op, vecs[v].ad, vecs[v].val);
            check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd1);
            wait_done($sformatf("vec%0d_done", v));
            check($sformatf("vec%0d_idle_at_done", v), {31'd0, busy}, 32'd0);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_done_pulses", v), done_cnt, 32'd1);
            check_log($sformatf("vec%0d", v), 0, vecs[v].l1, vecs[v].l2);
            $display("vec %0d op=%b addr=%h value=%h bytes=%0d", v, vecs[v].op, vecs[v].ad,
                     vecs[v].val, log_q.size());
        end

        // Extra starts and input churn while busy are ignored
        wait_idle("disp_idle");
        log_q.delete();
        done_cnt = 0;
        pulse_start(3'b111, 4'hF, 16'd291);
        for (int k = 0; k < 4; k++) begin
            repeat (40) @(negedge clk);
            pulse_start(3'($urandom_range(0, 6)), 4'($urandom_range(0, 14)), 16'($urandom));
        end
        opcode = 3'b000;
        addr   = 4'h1;
        value  = 16'h1111;
        wait_done("disp_done");
        repeat (30) @(negedge clk);
        check("disp_byte_total", log_q.size(), 32'd34);
        check("disp_done_pulses", done_cnt, 32'd1);
        check("disp_busy_after", {31'd0, busy}, 32'd0);
        check_log("disp", 0, pad16("DISP RF"), pad16("=+00291"));
        $display("disp refresh bytes=%0d done=%0d", log_q.size(), done_cnt);

        // start held high: a new capture on the first IDLE cycle after each done
        wait_idle("held_idle");
        log_q.delete();
        done_cnt = 0;
        opcode = 3'b101;
        addr   = 4'h1;
        value  = 16'd42;
        start  = 1'b1;
        @(negedge clk);
        check("held_busy", {31'd0, busy}, 32'd1);
        wait_done("held_done1");
        check("held_idle_at_done1", {31'd0, busy}, 32'd0);
        value = 16'hFFFB;
        @(negedge clk);
        check("held_recapture", {31'd0, busy}, 32'd1);
        wait_done("held_done2");
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("held_stopped", {31'd0, busy}, 32'd0);
        check("held_done_pulses", done_cnt, 32'd2);
        check_log("held1", 0, pad16("MUL  R1"), pad16("=+00042"));
        check_log("held2", 34, pad16("MUL  R1"), pad16("=-00005"));
        $display("held-start refreshes bytes=%0d done=%0d", log_q.size(), done_cnt);

        // Reset in the middle of a WRITE
        wait_idle("mid_idle");
        log_q.delete();
        pulse_start(3'b000, 4'h2, 16'd100);
        begin
            int n = 0;
            while (log_q.size() < 10 && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        check("mid_reach_byte10", 32'(log_q.size() >= 10), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_en", {31'd0, lcd_en}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        log_q.delete();
        gaps.delete();
        seen_fall = 0;
        begin
            // Cycles from the reset edge to the first strobe: power-up wait plus setup cycle.
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (lcd_en !== 1'b1 && n < 500);
            check("mid_pwrup_len", n, P_PWR + 1);
        end
        wait_idle("mid_reinit_idle");
        check_init("reinit");
        $display("mid-write reset reinit bytes=%0d", log_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_result_writer.md
Name: lcd_result_writer

Overview:
- Downstream consumer of the mini CPU's display path. Takes the latched opcode, destination address and 16-bit signed result.
- Formats them as two 16-character text lines and drives an HD44780-compatible character LCD over its 8-bit parallel bus.
- Owns the LCD power-up/init sequence. Signals the CPU via busy/done so a new result is only accepted when the display is idle.

Parameters:
- POWERUP_CYC, 750000, cycles waited after reset before the first command (15 ms @ 50 MHz)
- EN_CYC, 12, cycles lcd_en is held high per byte write
- CMD_CYC, 2000, cycles waited after lcd_en falls for a normal byte (40 us)
- CLR_CYC, 82000, cycles waited after lcd_en falls for the clear command 0x01 (1.64 ms)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a display refresh; sampled only in IDLE
- opcode  in  3  operation code to show
- addr  in  4  destination register index to show
- value  in  16  two's-complement result to show
- busy  out  1  high while initialising or writing
- done  out  1  one-cycle pulse when a refresh completes
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  0 = command, 1 = character
- lcd_rw  out  1  tied 0 (write only)
- lcd_en  out  1  LCD enable strobe
- lcd_on  out  1  tied 1

Behaviour:
- One clock (clk); rst is synchronous and active-high.
- Reset values: busy=1, done=0, lcd_en=0, lcd_rs=0, lcd_data=8'h00. lcd_rw=0 and lcd_on=1 at all times.
- Reset mid-operation: next edge forces the reset values and restarts from PWRUP. A partially written display is abandoned.
- States: PWRUP -> INIT -> IDLE -> CONVERT -> WRITE -> IDLE.
- PWRUP: wait POWERUP_CYC cycles.
- INIT: send commands 0x38, 0x0C, 0x01, 0x06 (rs=0) in order, then enter IDLE with busy=0.
- Byte write primitive (used by INIT and WRITE):
  - Cycle 0: drive lcd_data/lcd_rs.
  - Cycles 1..EN_CYC: lcd_en=1.
  - Then lcd_en=0 and wait CMD_CYC cycles (CLR_CYC if the byte is command 0x01).
  - lcd_data/lcd_rs stay stable from cycle 0 until the wait ends.
- IDLE, start=1: capture opcode/addr/value on that edge. busy=1 from the next cycle.
- start while busy is ignored, not queued. If start is still high on return to IDLE, a new refresh begins.
- CONVERT (sequential, no combinational divider):
  - sign = value[15].
  - mag = 17-bit magnitude (0x8000 -> 32768).
  - Five decimal digits by repeated subtraction of 10000, 1000, 100, 10; the remainder is the units digit.
  - At most 45 subtract cycles.
- WRITE: 34 bytes in this order:
  - Command 0x80.
  - 16 characters of line 1.
  - Command 0xC0.
  - 16 characters of line 2.
- Line 1: 4-char mnemonic, space, 'R', uppercase hex addr digit, 9 spaces.
  - 000 "LOAD", 001 "ADD ", 010 "ADDI", 011 "SUB ", 100 "SUBI", 101 "MUL ", 110 "CLR ", 111 "DISP".
- Line 2: '=', sign char ('+' if value[15]=0, else '-'), 5 digits with leading zeros, 9 spaces. ASCII throughout.
- After the last byte's wait: done=1 for exactly one cycle, busy=0 in the same cycle, state IDLE.
- Captured operands are held throughout. Input changes during busy do not affect the display.

Test Plan:
Bench parameters: POWERUP_CYC=20, EN_CYC=2, CMD_CYC=4, CLR_CYC=8. The bench logs {rs, data} at every lcd_en falling edge.
- Reset 3 cycles, release -> busy=1, lcd_en=0 during reset; log 0:38, 0:0C, 0:01, 0:06; busy falls. Gap after 0x01 equals 8 cycles, others 4.
- start pulse, opcode=010, addr=5, value=0x0007 -> 0:80, "ADDI R5" + 9 spaces, 0:C0, "=+00007" + 9 spaces; one done pulse; busy low afterwards.
- Back-to-back refreshes with value 0x8000, 0xFFFF, 0x7FFF, 0x0000 -> line 2 "=-32768", "=-00001", "=+32767", "=+00000".
- opcode=111, addr=F; start pulsed 5 times and inputs toggled while busy -> exactly 34 bytes logged, content "DISP RF" from the captured values, one done.
- rst asserted at byte 10 of a WRITE -> next edge lcd_en=0, busy=1, done=0; after POWERUP_CYC the init sequence 38/0C/01/06 restarts.
- start held high continuously -> refreshes repeat, each done followed by a new capture on the first IDLE cycle.
